// File: rtl/motor_supervisor_if.sv
// Command channel into motor_supervisor: valid/ready handshake carrying a 2-bit opcode
// (0=NOP 1=UP 2=DN 3=STOP).
interface motor_supervisor_if;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic       cmd_ready;

  modport master (output cmd_valid, output cmd_op, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, output cmd_ready);
endinterface

// File: rtl/motor_supervisor.sv
// Sequencer for one bidirectional motor: accepts UP/DN/STOP commands, enforces dead-time
// between any stop and the next start, times out long travels and traps on inconsistent limits.
module motor_supervisor #(
  parameter int unsigned DEAD_CYC    = 16,
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  motor_supervisor_if.slave  cmd_if,
  input  logic               up_limit_i,
  input  logic               dn_limit_i,
  input  logic               fault_clr_i,
  output logic               motor_up_o,
  output logic               motor_dn_o,
  output logic               busy_o,
  output logic               fault_o
);

  typedef enum logic [2:0] {ST_IDLE, ST_RUN_UP, ST_RUN_DN, ST_DEAD, ST_FAULT} state_e;
  typedef enum logic [1:0] {PEND_NONE, PEND_UP, PEND_DN} pend_e;

  localparam logic [1:0] OP_UP   = 2'd1;
  localparam logic [1:0] OP_DN   = 2'd2;
  localparam logic [1:0] OP_STOP = 2'd3;

  localparam logic [CNT_W-1:0] DEAD_LAST    = CNT_W'(DEAD_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_e           state_q, state_d;
  pend_e            pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             motor_up_q, motor_dn_q, busy_q, fault_q;

  logic  cmd_ready, cmd_fire, op_up, op_dn, op_stop, both_limits;
  logic  run_up, run_limit, reverse;
  pend_e rev_pend;

  assign cmd_ready        = (state_q == ST_IDLE) || (state_q == ST_RUN_UP) || (state_q == ST_RUN_DN);
  assign cmd_if.cmd_ready = cmd_ready;
  assign cmd_fire         = cmd_if.cmd_valid & cmd_ready;
  assign op_up            = cmd_fire & (cmd_if.cmd_op == OP_UP);
  assign op_dn            = cmd_fire & (cmd_if.cmd_op == OP_DN);
  assign op_stop          = cmd_fire & (cmd_if.cmd_op == OP_STOP);
  assign both_limits      = up_limit_i & dn_limit_i;

  // Both RUN states share one body; these pick the limit and reversal that apply to the travel.
  assign run_up    = (state_q == ST_RUN_UP);
  assign run_limit = run_up ? up_limit_i : dn_limit_i;
  assign reverse   = run_up ? op_dn : op_up;
  assign rev_pend  = run_up ? PEND_DN : PEND_UP;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    state_d = state_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    if (both_limits && (state_q != ST_FAULT)) begin
      state_d = ST_FAULT;
      pend_d  = PEND_NONE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (op_up && !up_limit_i)      state_d = ST_RUN_UP;
          else if (op_dn && !dn_limit_i) state_d = ST_RUN_DN;
        end
        ST_RUN_UP, ST_RUN_DN: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (run_limit) begin
            state_d = ST_DEAD;
            cnt_d   = '0;
            if (reverse) pend_d = rev_pend;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d = ST_FAULT;
            cnt_d   = '0;
          end else if (op_stop || reverse) begin
            state_d = ST_DEAD;
            cnt_d   = '0;
            pend_d  = reverse ? rev_pend : PEND_NONE;
          end
        end
        ST_DEAD: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == DEAD_LAST) begin
            cnt_d   = '0;
            pend_d  = PEND_NONE;
            state_d = ST_IDLE;
            if ((pend_q == PEND_UP) && !up_limit_i)      state_d = ST_RUN_UP;
            else if ((pend_q == PEND_DN) && !dn_limit_i) state_d = ST_RUN_DN;
          end
        end
        ST_FAULT: begin
          cnt_d = '0;
          if (fault_clr_i) begin
            state_d = ST_IDLE;
            pend_d  = PEND_NONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          pend_d  = PEND_NONE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output flops load from the next state so the pins are true registers yet track the state edge.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q    <= ST_IDLE;
      pend_q     <= PEND_NONE;
      cnt_q      <= '0;
      motor_up_q <= 1'b0;
      motor_dn_q <= 1'b0;
      busy_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      motor_up_q <= (state_d == ST_RUN_UP);
      motor_dn_q <= (state_d == ST_RUN_DN);
      busy_q     <= (state_d == ST_RUN_UP) || (state_d == ST_RUN_DN) || (state_d == ST_DEAD);
      fault_q    <= (state_d == ST_FAULT);
    end
  end

  assign motor_up_o = motor_up_q;
  assign motor_dn_o = motor_dn_q;
  assign busy_o     = busy_q;
  assign fault_o    = fault_q;

endmodule

// File: tb/tb_motor_supervisor.sv
// Self-checking bench for motor_supervisor: directed scenarios with literal expectations,
// then randomized stimulus compared every cycle against a behavioural travel/dead-time model.
module tb_motor_supervisor;
  localparam int DEAD_CYC    = 4;
  localparam int TIMEOUT_CYC = 20;
  localparam logic [1:0] OP_NOP = 2'd0, OP_UP = 2'd1, OP_DN = 2'd2, OP_STOP = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic up_limit = 1'b0, dn_limit = 1'b0, fault_clr = 1'b0;
  logic motor_up, motor_dn, busy, fault;
  int   n_tests = 0;
  int   n_fail  = 0;

  motor_supervisor_if cmd_if ();

  motor_supervisor #(.DEAD_CYC(DEAD_CYC), .TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_if      (cmd_if),
    .up_limit_i  (up_limit),
    .dn_limit_i  (dn_limit),
    .fault_clr_i (fault_clr),
    .motor_up_o  (motor_up),
    .motor_dn_o  (motor_dn),
    .busy_o      (busy),
    .fault_o     (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: travel direction (+1 up, -1 down, 0 none), dead cycles still owed, cycles travelled,
  // queued reversal direction and a fault latch.
  int m_dir = 0, m_dead = 0, m_age = 0, m_queued = 0;
  bit m_fault = 1'b0, m_valid = 1'b0;

  function automatic bit at_limit(input int d);
    return (d > 0) ? up_limit : dn_limit;
  endfunction

  always @(posedge clk) begin : model
    bit acc, is_stop;
    int want;
    acc     = cmd_if.cmd_valid && !m_fault && (m_dead == 0);
    want    = !acc ? 0 : (cmd_if.cmd_op == OP_UP) ? 1 : (cmd_if.cmd_op == OP_DN) ? -1 : 0;
    is_stop = acc && (cmd_if.cmd_op == OP_STOP);
    if (rst) begin
      m_dir = 0; m_dead = 0; m_age = 0; m_queued = 0; m_fault = 1'b0; m_valid = 1'b1;
    end else if (!m_fault && up_limit && dn_limit) begin
      m_fault = 1'b1; m_dir = 0; m_dead = 0; m_queued = 0;
    end else if (m_fault) begin
      if (fault_clr) m_fault = 1'b0;
    end else if (m_dead > 0) begin
      m_dead--;
      if (m_dead == 0) begin
        if (m_queued != 0 && !at_limit(m_queued)) begin
          m_dir = m_queued; m_age = 0;
        end
        m_queued = 0;
      end
    end else if (m_dir == 0) begin
      if (want != 0 && !at_limit(want)) begin
        m_dir = want; m_age = 0;
      end
    end else begin
      m_age++;
      if (at_limit(m_dir)) begin
        if (want == -m_dir) m_queued = want;
        m_dir = 0; m_dead = DEAD_CYC;
      end else if (m_age == TIMEOUT_CYC) begin
        m_fault = 1'b1; m_dir = 0;
      end else if (is_stop || want == -m_dir) begin
        m_queued = (want == -m_dir) ? want : 0;
        m_dir = 0; m_dead = DEAD_CYC;
      end
    end
  end

  logic prev_on = 1'b0;
  int   low_run = 0;
  bit   exempt  = 1'b1;

  always @(negedge clk) begin : compare
    logic on;
    if (m_valid) begin
      check("motor_up", motor_up, m_dir > 0);
      check("motor_dn", motor_dn, m_dir < 0);
      check("busy", busy, (m_dir != 0) || (m_dead > 0));
      check("fault", fault, m_fault);
      check("cmd_ready", cmd_if.cmd_ready, !m_fault && (m_dead == 0));
      check("motors_exclusive", motor_up & motor_dn, 1'b0);
      on = motor_up | motor_dn;
      if (on && !prev_on) begin
        if (!exempt) check("dead_gap", low_run >= DEAD_CYC, 1'b1);
        exempt = 1'b0;
      end
      if (on) low_run = 0;
      else    low_run++;
      if (fault || rst) exempt = 1'b1;
      prev_on = on;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cyc(1);
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = OP_NOP;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = OP_NOP;
    cyc(2);
    rst = 1'b0;
    check("rst_motor_up", motor_up, 1'b0);
    check("rst_motor_dn", motor_dn, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_fault", fault, 1'b0);
    check("rst_ready", cmd_if.cmd_ready, 1'b1);

    // Travel up, stop at the limit, dead-time, back to idle.
    send(OP_UP);
    check("a_up_on", motor_up, 1'b1);
    cyc(8);
    up_limit = 1'b1;
    cyc(1);
    check("a_limit_off", motor_up, 1'b0);
    check("a_busy_dead", busy, 1'b1);
    check("a_ready_dead", cmd_if.cmd_ready, 1'b0);
    cyc(3);
    check("a_busy_last_dead", busy, 1'b1);
    cyc(1);
    check("a_idle", busy, 1'b0);
    up_limit = 1'b0;

    // Reversal: UP then DN goes through exactly DEAD_CYC low cycles.
    send(OP_UP);
    check("b_up_on", motor_up, 1'b1);
    cyc(3);
    send(OP_DN);
    check("b_up_off", motor_up, 1'b0);
    check("b_dn_wait", motor_dn, 1'b0);
    check("b_ready_dead", cmd_if.cmd_ready, 1'b0);
    cyc(3);
    check("b_dn_still_low", motor_dn, 1'b0);
    check("b_ready_dead_end", cmd_if.cmd_ready, 1'b0);
    cyc(1);
    check("b_dn_on", motor_dn, 1'b1);
    send(OP_STOP);
    check("b_dn_off", motor_dn, 1'b0);
    cyc(4);
    check("b_idle", busy, 1'b0);

    // Timeout: motor_up holds exactly TIMEOUT_CYC cycles, then fault.
    send(OP_UP);
    cyc(18);
    check("c_up_19", motor_up, 1'b1);
    cyc(1);
    check("c_up_20", motor_up, 1'b1);
    check("c_no_fault_yet", fault, 1'b0);
    cyc(1);
    check("c_fault", fault, 1'b1);
    check("c_up_off", motor_up, 1'b0);
    check("c_ready_fault", cmd_if.cmd_ready, 1'b0);
    fault_clr = 1'b1;
    cyc(1);
    fault_clr = 1'b0;
    check("c_cleared", fault, 1'b0);
    check("c_ready_after", cmd_if.cmd_ready, 1'b1);

    // Both limits during RUN_DN trap immediately and block commands.
    send(OP_DN);
    check("d_dn_on", motor_dn, 1'b1);
    cyc(2);
    up_limit = 1'b1;
    dn_limit = 1'b1;
    cyc(1);
    check("d_fault", fault, 1'b1);
    check("d_dn_off", motor_dn, 1'b0);
    check("d_ready", cmd_if.cmd_ready, 1'b0);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = OP_UP;
    cyc(2);
    check("d_up_blocked", motor_up, 1'b0);
    cmd_if.cmd_valid = 1'b0;
    up_limit = 1'b0;
    dn_limit = 1'b0;
    fault_clr = 1'b1;
    cyc(1);
    fault_clr = 1'b0;
    check("d_cleared", fault, 1'b0);

    // UP into an active up limit: accepted but does nothing.
    up_limit = 1'b1;
    check("e_ready", cmd_if.cmd_ready, 1'b1);
    send(OP_UP);
    check("e_up_off", motor_up, 1'b0);
    check("e_busy", busy, 1'b0);
    up_limit = 1'b0;

    // Reset mid-travel, then restart with no dead-time owed.
    send(OP_DN);
    cyc(3);
    rst = 1'b1;
    cyc(1);
    check("f_rst_dn_off", motor_dn, 1'b0);
    check("f_rst_busy", busy, 1'b0);
    rst = 1'b0;
    send(OP_DN);
    check("f_dn_restart", motor_dn, 1'b1);
    send(OP_STOP);
    cyc(4);

    for (int i = 0; i < 3000; i++) begin
      cmd_if.cmd_valid = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 11) == 0);
      cmd_if.cmd_op    = 2'($urandom_range(0, 3));
      up_limit         = ($urandom_range(0, 39) == 0);
      dn_limit         = ($urandom_range(0, 39) == 0);
      fault_clr        = ($urandom_range(0, 7) == 0);
      rst              = ($urandom_range(0, 299) == 0);
      cyc(1);
    end
    cmd_if.cmd_valid = 1'b0;
    rst = 1'b0;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
